// File: rtl/alu_mc_controller.sv
// -----------------------------------------------------------------------------
// alu_mc_controller
//
// Multicycle MIPS-subset control unit: a Moore FSM that sequences fetch,
// decode, execute, memory and write-back steps, plus the ALU decoder.
// Supported instructions: lw, sw, R-type (add/sub/and/or/slt), beq, addi, j.
//
// Ports
//   clk        in   1  clock, all state changes on the rising edge
//   reset      in   1  synchronous, active-high
//   op         in   6  opcode from the instruction register
//   funct      in   6  R-type function field from the instruction register
//   zero       in   1  ALU zero flag (qualifies branches)
//   mem_ready  in   1  memory access completes this cycle
//   iord       out  1  memory address select (0 = PC, 1 = ALUOut)
//   memwrite   out  1  data memory write enable
//   irwrite    out  1  instruction register write enable
//   regdst     out  1  register file destination select (1 = rd)
//   memtoreg   out  1  register write data select (1 = memory data)
//   regwrite   out  1  register file write enable
//   alusrca    out  1  ALU A select (0 = PC, 1 = register A)
//   alusrcb    out  2  ALU B select (00 B, 01 +4, 10 sign-ext imm, 11 branch off)
//   pcsrc      out  2  next-PC select (00 ALU result, 01 ALUOut, 10 jump target)
//   pcen       out  1  PC load enable
//   alucontrol out  3  ALU operation
//   instr_done out  1  pulse on the final cycle of every instruction
//   illegal    out  1  pulse when DECODE sees an unsupported op / funct
// -----------------------------------------------------------------------------
module alu_mc_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic       pcen,
    output logic [2:0] alucontrol,
    output logic       instr_done,
    output logic       illegal
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JEX     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    state_t     state_q, state_d;

    // Ungated decode of the current state; write-type strobes are masked by
    // reset below so nothing is committed while reset is high.
    logic       pcwrite, branch;
    logic [1:0] aluop;
    logic       memwrite_raw, irwrite_raw, regwrite_raw;
    logic       done_raw, illegal_raw;
    logic       funct_ok;

    always_comb begin
        funct_ok = (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
                   (funct == FN_OR)  || (funct == FN_SLT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = S_FETCH;
        iord         = 1'b0;
        memwrite_raw = 1'b0;
        irwrite_raw  = 1'b0;
        regdst       = 1'b0;
        memtoreg     = 1'b0;
        regwrite_raw = 1'b0;
        alusrca      = 1'b0;
        alusrcb      = 2'b00;
        pcsrc        = 2'b00;
        pcwrite      = 1'b0;
        branch       = 1'b0;
        aluop        = 2'b00;
        done_raw     = 1'b0;
        illegal_raw  = 1'b0;

        case (state_q)
            S_FETCH: begin
                alusrcb     = 2'b01;
                irwrite_raw = mem_ready;
                pcwrite     = mem_ready;
                state_d     = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alusrcb = 2'b11;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_BEQ:       state_d = S_BEQEX;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JEX;
                    OP_RTYPE: begin
                        if (funct_ok) begin
                            state_d = S_RTYPEEX;
                        end else begin
                            illegal_raw = 1'b1;
                        end
                    end
                    default:      illegal_raw = 1'b1;
                endcase
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                iord    = 1'b1;
                state_d = mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                memtoreg     = 1'b1;
                regwrite_raw = 1'b1;
                done_raw     = 1'b1;
            end
            S_MEMWR: begin
                // The write strobe stays up for the whole wait; the memory
                // takes it on the cycle it raises mem_ready.
                iord         = 1'b1;
                memwrite_raw = 1'b1;
                done_raw     = mem_ready;
                state_d      = mem_ready ? S_FETCH : S_MEMWR;
            end
            S_RTYPEEX: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
                state_d = S_RTYPEWB;
            end
            S_RTYPEWB: begin
                regdst       = 1'b1;
                regwrite_raw = 1'b1;
                done_raw     = 1'b1;
            end
            S_BEQEX: begin
                alusrca  = 1'b1;
                aluop    = 2'b01;
                pcsrc    = 2'b01;
                branch   = 1'b1;
                done_raw = 1'b1;
            end
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = S_ADDIWB;
            end
            S_ADDIWB: begin
                regwrite_raw = 1'b1;
                done_raw     = 1'b1;
            end
            S_JEX: begin
                pcsrc    = 2'b10;
                pcwrite  = 1'b1;
                done_raw = 1'b1;
            end
            default: state_d = S_FETCH;  // unused codes 12-15 recover
        endcase
    end

    // ALU decoder; aluop 11 is never produced and decodes like 10.
    always_comb begin
        alucontrol = 3'b010;
        case (aluop)
            2'b00: alucontrol = 3'b010;
            2'b01: alucontrol = 3'b110;
            default: begin
                case (funct)
                    FN_ADD:  alucontrol = 3'b010;
                    FN_SUB:  alucontrol = 3'b110;
                    FN_AND:  alucontrol = 3'b000;
                    FN_OR:   alucontrol = 3'b001;
                    FN_SLT:  alucontrol = 3'b111;
                    default: alucontrol = 3'b010;
                endcase
            end
        endcase
    end

    // Reset masks every strobe that could commit state anywhere.
    always_comb begin
        memwrite   = memwrite_raw & ~reset;
        irwrite    = irwrite_raw  & ~reset;
        regwrite   = regwrite_raw & ~reset;
        pcen       = (pcwrite | (branch & zero)) & ~reset;
        instr_done = done_raw     & ~reset;
        illegal    = illegal_raw  & ~reset;
    end

endmodule

// File: tb/tb_alu_mc_controller.sv
// -----------------------------------------------------------------------------
// tb_alu_mc_controller
//
// Directed instruction sequences with hand-computed expectations. Each issued
// instruction pushes its expected completion record into a queue; a monitor
// accumulates per-instruction activity (cycles, strobe counts, ALU op) and
// checks it against the popped record whenever instr_done or illegal fires.
// -----------------------------------------------------------------------------
module tb_alu_mc_controller;

    logic       clk;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic       pcen;
    logic [2:0] alucontrol;
    logic       instr_done, illegal;

    alu_mc_controller dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .iord       (iord),
        .memwrite   (memwrite),
        .irwrite    (irwrite),
        .regdst     (regdst),
        .memtoreg   (memtoreg),
        .regwrite   (regwrite),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .pcsrc      (pcsrc),
        .pcen       (pcen),
        .alucontrol (alucontrol),
        .instr_done (instr_done),
        .illegal    (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] id;
        logic [7:0] lat;
        logic       ill;
        logic [7:0] n_iord;
        logic [7:0] n_rw;
        logic [7:0] n_mw;
        logic [7:0] n_ir;
        logic [7:0] n_pcen;
        logic [7:0] n_mtr;
        logic [7:0] n_rd;
        logic       chk_alu;
        logic [2:0] alu;
        logic [1:0] pcsrc;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string what, input int id, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s (instr %0d): got %0d, expected %0d", what, id, act, req);
        end
    endtask

    function automatic exp_t mk(input int id, input int lat, input bit ill,
                                input int n_iord, input int n_rw, input int n_mw,
                                input int n_ir, input int n_pcen, input int n_mtr,
                                input int n_rd, input bit chk_alu,
                                input logic [2:0] alu, input logic [1:0] ps);
        exp_t e;
        e.id = id[7:0];         e.lat = lat[7:0];       e.ill = ill;
        e.n_iord = n_iord[7:0]; e.n_rw = n_rw[7:0];     e.n_mw = n_mw[7:0];
        e.n_ir = n_ir[7:0];     e.n_pcen = n_pcen[7:0]; e.n_mtr = n_mtr[7:0];
        e.n_rd = n_rd[7:0];     e.chk_alu = chk_alu;    e.alu = alu;
        e.pcsrc = ps;
        return e;
    endfunction

    // ---------------- monitor ----------------
    int         w_cyc, w_iord, w_rw, w_mw, w_ir, w_pcen, w_mtr, w_rd;
    logic [2:0] w_alu;

    task automatic clear_window();
        w_cyc = 0; w_iord = 0; w_rw = 0; w_mw = 0; w_ir = 0;
        w_pcen = 0; w_mtr = 0; w_rd = 0; w_alu = 3'b000;
    endtask

    initial clear_window();

    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            clear_window();
        end else begin
            w_cyc++;
            if (iord)     w_iord++;
            if (regwrite) w_rw++;
            if (memwrite) w_mw++;
            if (irwrite)  w_ir++;
            if (pcen)     w_pcen++;
            if (memtoreg) w_mtr++;
            if (regdst)   w_rd++;
            if (alusrca && alusrcb == 2'b00) w_alu = alucontrol;
            if (instr_done || illegal) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_completion", 0, 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    $display("instr %0d: done=%0b illegal=%0b cycles=%0d", e.id,
                             instr_done, illegal, w_cyc);
                    chk("illegal_flag", e.id, illegal, e.ill);
                    chk("done_flag",    e.id, instr_done, !e.ill);
                    chk("latency",      e.id, w_cyc,  e.lat);
                    chk("iord_cycles",  e.id, w_iord, e.n_iord);
                    chk("regwrite_cnt", e.id, w_rw,   e.n_rw);
                    chk("memwrite_cnt", e.id, w_mw,   e.n_mw);
                    chk("irwrite_cnt",  e.id, w_ir,   e.n_ir);
                    chk("pcen_cnt",     e.id, w_pcen, e.n_pcen);
                    chk("memtoreg_cnt", e.id, w_mtr,  e.n_mtr);
                    chk("regdst_cnt",   e.id, w_rd,   e.n_rd);
                    chk("pcsrc_final",  e.id, pcsrc,  e.pcsrc);
                    if (e.chk_alu) chk("alucontrol_ex", e.id, w_alu, e.alu);
                end
                clear_window();
            end
        end
    end

    // ---------------- stimulus ----------------
    localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010;
    localparam logic [15:0] ALL = 16'hFFFF;

    // Entered and left at posedge+1; rdy[i] is mem_ready for cycle i.
    task automatic run(input logic [5:0] o, input logic [5:0] f, input logic z,
                       input logic [15:0] rdy, input int n, input exp_t e);
        exp_q.push_back(e);
        op = o; funct = f; zero = z;
        for (int i = 0; i < n; i++) begin
            mem_ready = rdy[i];
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        reset = 1'b1; op = OP_R; funct = 6'b100000; zero = 1'b0; mem_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        // FETCH under reset with mem_ready=1: strobes must all be masked.
        chk("reset_strobes", 0,
            {memwrite, irwrite, regwrite, pcen, instr_done, illegal}, 0);
        chk("reset_state_fetch_alusrcb", 0, alusrcb, 2'b01);
        reset = 1'b0;

        // Back-to-back j, addi, sw: done at cycles 3, 7, 11.
        run(OP_J,    6'd0, 1'b0, ALL, 3, mk(1, 3, 0, 0, 0, 0, 1, 2, 0, 0, 0, 3'b000, 2'b10));
        run(OP_ADDI, 6'd0, 1'b0, ALL, 4, mk(2, 4, 0, 0, 1, 0, 1, 1, 0, 0, 0, 3'b000, 2'b00));
        run(OP_SW,   6'd0, 1'b0, ALL, 4, mk(3, 4, 0, 1, 0, 1, 1, 1, 0, 0, 0, 3'b000, 2'b00));

        // sub; mem_ready dropped in DECODE/RTYPEEX must not stall.
        run(OP_R, 6'b100010, 1'b0, 16'h0009, 4, mk(4, 4, 0, 0, 1, 0, 1, 1, 0, 1, 1, 3'b110, 2'b00));
        // add with one FETCH wait cycle.
        run(OP_R, 6'b100000, 1'b0, 16'h001E, 5, mk(5, 5, 0, 0, 1, 0, 1, 1, 0, 1, 1, 3'b010, 2'b00));
        run(OP_R, 6'b100100, 1'b0, ALL, 4, mk(6, 4, 0, 0, 1, 0, 1, 1, 0, 1, 1, 3'b000, 2'b00));
        run(OP_R, 6'b100101, 1'b0, ALL, 4, mk(7, 4, 0, 0, 1, 0, 1, 1, 0, 1, 1, 3'b001, 2'b00));
        run(OP_R, 6'b101010, 1'b0, ALL, 4, mk(8, 4, 0, 0, 1, 0, 1, 1, 0, 1, 1, 3'b111, 2'b00));

        // lw with three MEMRD wait cycles: iord held 4 cycles.
        run(OP_LW, 6'd0, 1'b0, 16'h00C7, 8, mk(9, 8, 0, 4, 1, 0, 1, 1, 1, 0, 0, 3'b000, 2'b00));

        // beq taken / not taken.
        run(OP_BEQ, 6'd0, 1'b1, ALL, 3, mk(10, 3, 0, 0, 0, 0, 1, 2, 0, 0, 1, 3'b110, 2'b01));
        run(OP_BEQ, 6'd0, 1'b0, ALL, 3, mk(11, 3, 0, 0, 0, 0, 1, 1, 0, 0, 1, 3'b110, 2'b01));

        // Illegal opcode and illegal R-type funct.
        run(6'b111111, 6'd0,      1'b0, ALL, 2, mk(12, 2, 1, 0, 0, 0, 1, 1, 0, 0, 0, 3'b000, 2'b00));
        run(OP_R,      6'b000111, 1'b0, ALL, 2, mk(13, 2, 1, 0, 0, 0, 1, 1, 0, 0, 0, 3'b000, 2'b00));

        // sw aborted by reset during the MEMWR wait.
        op = OP_SW; funct = 6'd0; zero = 1'b0; mem_ready = 1'b1;
        @(posedge clk); #1;            // FETCH -> DECODE
        @(posedge clk); #1;            // DECODE -> MEMADR
        @(posedge clk); #1;            // MEMADR -> MEMWR
        mem_ready = 1'b0;
        #1;
        chk("memwr_wait_memwrite", 14, memwrite, 1);
        chk("memwr_wait_iord",     14, iord, 1);
        @(posedge clk); #1;            // still waiting in MEMWR
        reset = 1'b1;
        #1;
        chk("abort_memwrite", 14, memwrite, 0);
        chk("abort_done",     14, instr_done, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Must restart from FETCH: j completes in 3 cycles.
        run(OP_J, 6'd0, 1'b0, ALL, 3, mk(15, 3, 0, 0, 0, 0, 1, 2, 0, 0, 0, 3'b000, 2'b10));

        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("queue_drained", 0, exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_mc_controller.md
ALU_MC_CONTROLLER -- requirements
Module: alu_mc_controller

Interface
REQ-001 Parameters: none.
REQ-002 The block SHALL have exactly these ports: clk, reset, op, funct, zero, mem_ready, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, alusrcb, pcsrc, pcen, alucontrol, instr_done, illegal.
REQ-003 clk  input  1  single clock, all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-high.
REQ-005 op  input  6  opcode from instruction register.
REQ-006 funct  input  6  function field from instruction register.
REQ-007 zero  input  1  ALU zero flag.
REQ-008 mem_ready  input  1  memory access complete this cycle.
REQ-009 iord  output  1  memory address select (0 = PC, 1 = ALUOut).
REQ-010 memwrite, irwrite, regwrite  output  1 each  write enables.
REQ-011 regdst, memtoreg, alusrca  output  1 each  datapath mux selects.
REQ-012 alusrcb, pcsrc  output  2 each  datapath mux selects.
REQ-013 pcen  output  1  PC load = pcwrite | (branch & zero); pcwrite and branch are internal.
REQ-014 alucontrol  output  3  ALU operation, from internal aluop[1:0] and funct.
REQ-015 instr_done  output  1  one-cycle pulse on final cycle of each instruction.
REQ-016 illegal  output  1  one-cycle pulse on unsupported op or R-type funct.

Function
REQ-017 The block SHALL be a Moore FSM: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPEEX=6, RTYPEWB=7, BEQEX=8, ADDIEX=9, ADDIWB=10, JEX=11; codes 12-15 SHALL go to FETCH.
REQ-018 Outputs not listed for a state SHALL be 0.
REQ-019 FETCH: alusrcb=01, aluop=00; irwrite=pcwrite=mem_ready; stay while mem_ready=0, else DECODE.
REQ-020 DECODE: alusrcb=11, aluop=00; next by op: 100011/101011->MEMADR, 000000 with supported funct->RTYPEEX, 000100->BEQEX, 001000->ADDIEX, 000010->JEX; anything else->FETCH with illegal=1.
REQ-021 MEMADR: alusrca=1, alusrcb=10, aluop=00; op 100011->MEMRD, else MEMWR.
REQ-022 MEMRD: iord=1; stay while mem_ready=0, else MEMWB.
REQ-023 MEMWB: memtoreg=1, regwrite=1, instr_done=1; ->FETCH.
REQ-024 MEMWR: iord=1, memwrite=1 held until mem_ready; instr_done=mem_ready; ->FETCH when mem_ready=1.
REQ-025 RTYPEEX: alusrca=1, aluop=10; ->RTYPEWB. RTYPEWB: regdst=1, regwrite=1, instr_done=1; ->FETCH.
REQ-026 BEQEX: alusrca=1, aluop=01, pcsrc=01, branch=1, instr_done=1; ->FETCH.
REQ-027 ADDIEX: alusrca=1, alusrcb=10, aluop=00; ->ADDIWB. ADDIWB: regwrite=1, instr_done=1; ->FETCH.
REQ-028 JEX: pcsrc=10, pcwrite=1, instr_done=1; ->FETCH.
REQ-029 alucontrol SHALL be: aluop 00->010; 01->110; 1x by funct: 100000->010, 100010->110, 100100->000, 100101->001, 101010->111; any other funct->010.
REQ-030 Supported R-type funct set SHALL be exactly the five in REQ-029; others are illegal in DECODE.
REQ-031 mem_ready asserted outside FETCH, MEMRD and MEMWR SHALL be ignored.
REQ-032 Instruction latency with mem_ready=1 SHALL be: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3 cycles.

Reset
REQ-033 While reset=1, memwrite, irwrite, regwrite, pcen, instr_done and illegal SHALL be forced 0 combinationally; state SHALL be FETCH after the reset edge.
REQ-034 Reset asserted in any state, including a memory wait, SHALL abort the instruction with no further writes.

Verification
REQ-035 reset 2 cycles, mem_ready=1, op=000000, funct=100010 -> FETCH,DECODE,RTYPEEX,RTYPEWB; alucontrol=110 in RTYPEEX; regwrite=1, instr_done=1 in RTYPEWB.
REQ-036 lw (100011) with mem_ready=0 for 3 cycles in MEMRD -> iord=1 held 4 cycles; regwrite and memtoreg=1 exactly once.
REQ-037 beq (000100), zero=1 -> pcen=1, pcsrc=01 in BEQEX; zero=0 -> pcen=0 there.
REQ-038 op=111111, and op=000000 with funct=000111 -> illegal pulses 1 cycle, return to FETCH, no writes.
REQ-039 reset asserted during MEMWR wait -> memwrite=0 in that cycle, FETCH after edge.
REQ-040 Back-to-back j, addi, sw, all with mem_ready=1 -> instr_done pulses at cycles 3, 7 and 11.
